// File: rtl/nonce_uart_tx_pkg.sv
// Shared definitions for the nonce UART transmitter.
// Holds the ASCII constants, the message length, the state encodings of the
// top-level message FSM and the byte serializer, and the helpers that turn
// a nonce and a byte index into the ASCII character sent on the line.
package nonce_uart_tx_pkg;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam int unsigned MSG_BYTES = 10;

    // LOAD has no state of its own: issuing the next byte happens on the
    // same edge that leaves IDLE or finishes the previous byte.
    typedef enum logic {
        TOP_IDLE,
        TOP_WAIT
    } topState_t;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_START,
        SER_DATA,
        SER_STOP
    } serState_t;

    // Nibble to uppercase ASCII hex digit.
    function automatic logic [7:0] hexAscii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_0 + {4'h0, nib};
        end
        return ASCII_A + {4'h0, nib} - 8'd10;
    endfunction

    // Byte idx of the message: eight hex digits, most significant first,
    // then CR LF.
    function automatic logic [7:0] msgByte(input logic [31:0] word,
                                           input logic [3:0]  idx);
        logic [31:0] shifted;
        shifted = word >> (5'd28 - {idx[2:0], 2'b00});
        if (idx < 4'd8) begin
            return hexAscii(shifted[3:0]);
        end
        if (idx == 4'd8) begin
            return ASCII_CR;
        end
        return ASCII_LF;
    endfunction

endpackage

// File: rtl/nonce_uart_tx_byte.sv
// 8N1 byte serializer.
//   clock     : rising-edge clock
//   reset     : synchronous active-high reset, line returns to idle (1)
//   start     : load data and begin a frame (honoured while ready)
//   data      : byte to send, LSB first
//   tx        : serial line, idle high
//   byte_done : high during the last cycle of the stop bit
//   ready     : a start is accepted this cycle
// byte_done and ready are combinational so a start issued in the final
// stop-bit cycle is followed directly by the next start bit.
module uart_tx_byte
    import nonce_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       byte_done,
    output logic       ready
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    serState_t        state, stateNext;
    logic [CNT_W-1:0] baudCnt, baudNext;
    logic [2:0]       bitIdx, bitNext;
    logic [7:0]       shiftReg, shiftNext;
    logic             txReg, txNext;
    logic             wrap;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= SER_IDLE;
            baudCnt  <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            txReg    <= 1'b1;
        end else begin
            state    <= stateNext;
            baudCnt  <= baudNext;
            bitIdx   <= bitNext;
            shiftReg <= shiftNext;
            txReg    <= txNext;
        end
    end

    always_comb begin
        stateNext = state;
        baudNext  = baudCnt;
        bitNext   = bitIdx;
        shiftNext = shiftReg;
        txNext    = txReg;
        byte_done = 1'b0;
        ready     = 1'b0;
        wrap      = (baudCnt == BAUD_LAST);

        if (state != SER_IDLE) begin
            baudNext = wrap ? '0 : baudCnt + 1'b1;
        end

        case (state)
            SER_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    stateNext = SER_START;
                    baudNext  = '0;
                    shiftNext = data;
                    txNext    = 1'b0;
                end
            end
            SER_START: begin
                if (wrap) begin
                    stateNext = SER_DATA;
                    bitNext   = '0;
                    txNext    = shiftReg[0];
                end
            end
            SER_DATA: begin
                if (wrap) begin
                    shiftNext = {1'b0, shiftReg[7:1]};
                    if (bitIdx == 3'd7) begin
                        stateNext = SER_STOP;
                        txNext    = 1'b1;
                    end else begin
                        bitNext = bitIdx + 3'd1;
                        txNext  = shiftReg[1];
                    end
                end
            end
            SER_STOP: begin
                if (wrap) begin
                    byte_done = 1'b1;
                    ready     = 1'b1;
                    if (start) begin
                        stateNext = SER_START;
                        shiftNext = data;
                        txNext    = 1'b0;
                    end else begin
                        stateNext = SER_IDLE;
                        txNext    = 1'b1;
                    end
                end
            end
            default: begin
                stateNext = SER_IDLE;
                txNext    = 1'b1;
            end
        endcase
    end

    assign tx = txReg;

endmodule

// File: rtl/nonce_uart_tx.sv
// Reports a mined nonce to the host as "XXXXXXXX\r\n" over UART (8N1).
//   clock : board clock, rising edge
//   reset : synchronous active-high reset, abandons any message in flight
//   send  : request; accepted only while not busy
//   nonce : value latched in the accepting cycle
//   tx    : serial line, idle high
//   busy  : message in flight
//   done  : one-cycle pulse as the last stop bit completes
module nonce_uart_tx
    import nonce_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        send,
    input  logic [31:0] nonce,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] LAST_BYTE = 4'(MSG_BYTES - 1);

    topState_t   state, stateNext;
    logic [31:0] holdReg, holdNext;
    logic [3:0]  byteIdx, idxNext;
    logic        doneReg, doneNext;
    logic        serStart, serDone, serReady;
    logic [31:0] selWord;
    logic [3:0]  selIdx;
    logic [7:0]  serData;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= TOP_IDLE;
            holdReg <= '0;
            byteIdx <= '0;
            doneReg <= 1'b0;
        end else begin
            state   <= stateNext;
            holdReg <= holdNext;
            byteIdx <= idxNext;
            doneReg <= doneNext;
        end
    end

    // The first byte is taken straight from the nonce input because the
    // hold register is only written on the accepting edge; later bytes come
    // from the hold register.
    always_comb begin
        stateNext = state;
        holdNext  = holdReg;
        idxNext   = byteIdx;
        doneNext  = 1'b0;
        serStart  = 1'b0;
        selWord   = holdReg;
        selIdx    = byteIdx + 4'd1;

        case (state)
            TOP_IDLE: begin
                selWord = nonce;
                selIdx  = '0;
                if (send && serReady) begin
                    serStart  = 1'b1;
                    holdNext  = nonce;
                    idxNext   = '0;
                    stateNext = TOP_WAIT;
                end
            end
            TOP_WAIT: begin
                if (serDone) begin
                    if (byteIdx == LAST_BYTE) begin
                        stateNext = TOP_IDLE;
                        doneNext  = 1'b1;
                    end else begin
                        serStart = 1'b1;
                        idxNext  = byteIdx + 4'd1;
                    end
                end
            end
            default: stateNext = TOP_IDLE;
        endcase

        serData = msgByte(selWord, selIdx);
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) serializer (
        .clock    (clock),
        .reset    (reset),
        .start    (serStart),
        .data     (serData),
        .tx       (tx),
        .byte_done(serDone),
        .ready    (serReady)
    );

    assign busy = (state == TOP_WAIT);
    assign done = doneReg;

endmodule

// File: tb/tb_nonce_uart_tx.sv
module tb_nonce_uart_tx;

    localparam int unsigned CPB        = 4;
    localparam int unsigned FRAME      = 10 * CPB;
    localparam int unsigned MSG_CYCLES = 100 * CPB;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        send  = 1'b0;
    logic [31:0] nonce = '0;
    logic        tx, busy, done;

    always #5 clock = ~clock;

    nonce_uart_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .send (send),
        .nonce(nonce),
        .tx   (tx),
        .busy (busy),
        .done (done)
    );

    int          assertions = 0;
    int          failures   = 0;
    logic [7:0]  expQ[$];
    int unsigned remain  = 0;
    logic        expBusy = 1'b0;
    logic        expDone = 1'b0;
    bit          checkEn = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Uppercase hex digit: '0' is 48, 'A' is 65.
    function automatic logic [7:0] hexChar(input int unsigned v);
        if (v < 10) return 8'(48 + v);
        return 8'(65 + v - 10);
    endfunction

    // Reference model: a message occupies exactly 100 bit times after the
    // accepting edge; a request is taken only when no message is pending.
    initial begin
        forever begin
            @(posedge clock);
            expDone = 1'b0;
            if (reset) begin
                checkEn = 1'b1;
                remain  = 0;
                expBusy = 1'b0;
                expQ.delete();
            end else if (remain == 0 && send) begin
                remain  = MSG_CYCLES;
                expBusy = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    expQ.push_back(hexChar((nonce >> (28 - 4 * i)) & 32'hF));
                end
                expQ.push_back(8'h0D);
                expQ.push_back(8'h0A);
            end else if (remain != 0) begin
                remain = remain - 1;
                if (remain == 0) begin
                    expBusy = 1'b0;
                    expDone = 1'b1;
                end
            end
        end
    end

    // Monitor: per-cycle status checks plus a cycle-exact UART receiver
    // that pops the scoreboard for every complete frame.
    initial begin
        logic        rxActive;
        int unsigned n;
        logic        samp[FRAME];
        logic [7:0]  value;
        logic        shapeOk;
        rxActive = 1'b0;
        n = 0;
        forever begin
            @(negedge clock);
            if (checkEn) begin
                check("busy", busy, expBusy);
                check("done", done, expDone);
                if (!expBusy) check("idle_tx", tx, 1);
                if (reset) begin
                    rxActive = 1'b0;
                end else if (!rxActive) begin
                    if (tx === 1'b0) begin
                        rxActive = 1'b1;
                        samp[0]  = 1'b0;
                        n        = 1;
                    end
                end else begin
                    samp[n] = tx;
                    n++;
                    if (n == FRAME) begin
                        rxActive = 1'b0;
                        shapeOk  = 1'b1;
                        for (int b = 0; b < 10; b++) begin
                            for (int c = 1; c < int'(CPB); c++) begin
                                if (samp[b * CPB + c] !== samp[b * CPB]) shapeOk = 1'b0;
                            end
                        end
                        if (samp[0] !== 1'b0 || samp[9 * CPB] !== 1'b1) shapeOk = 1'b0;
                        for (int j = 0; j < 8; j++) value[j] = samp[(1 + j) * CPB];
                        check("frame_shape", shapeOk, 1);
                        if (expQ.size() == 0) begin
                            assertions++;
                            failures++;
                            $display("FAIL unexpected_byte: got %0h, expected no byte at %0t", value, $time);
                        end else begin
                            check("byte", value, expQ.pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic tick(input int unsigned cycles);
        repeat (cycles) @(posedge clock);
        #2;
    endtask

    task automatic sendPulse(input logic [31:0] v);
        nonce = v;
        send  = 1'b1;
        tick(1);
        send  = 1'b0;
    endtask

    task automatic waitIdle();
        int unsigned k;
        k = 0;
        while ((remain != 0 || busy !== 1'b0) && k < 2 * MSG_CYCLES) begin
            tick(1);
            k++;
        end
        assertions++;
        if (k >= 2 * MSG_CYCLES) begin
            failures++;
            $display("FAIL wait_idle: got busy=%0b after %0d cycles, expected 0", busy, k);
        end
        tick(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish by %0t", $time);
        $fatal(1);
    end

    initial begin
        tick(3);
        reset = 1'b0;
        tick(50);

        sendPulse(32'h42A14695);
        waitIdle();

        sendPulse(32'hFFFFFFFF);
        waitIdle();
        sendPulse(32'h00000000);
        waitIdle();

        // Nonce changes and a second request while busy must be ignored.
        sendPulse(32'h12345678);
        tick(9);
        nonce = 32'hDEADBEEF;
        tick(40);
        send = 1'b1;
        tick(1);
        send = 1'b0;
        waitIdle();
        tick(20);

        // Abandon a message with reset, then send a fresh one.
        sendPulse($urandom);
        tick(118);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(10);
        sendPulse($urandom);
        waitIdle();

        // Request held high: messages run back to back.
        nonce = 32'h0000000A;
        send  = 1'b1;
        tick(2 * MSG_CYCLES + 50);
        send  = 1'b0;
        waitIdle();

        for (int r = 0; r < 4; r++) begin
            tick($urandom_range(0, 20));
            sendPulse($urandom);
            tick($urandom_range(1, 300));
            nonce = $urandom;
            waitIdle();
        end

        tick(10);
        check("queue_empty", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
